// File: rtl/spi_frame_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_master
// Function : SPI mode-0 master; sends one 128-bit frame on sdo and captures
//            128 bits from sdi inside a single load-high window.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_master #(
    parameter int FRAME_BITS = 128,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [FRAME_BITS-1:0] tx_frame,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  abort,
    output logic [FRAME_BITS-1:0] rx_frame,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sck,
    output logic                  sdo,
    input  logic                  sdi,
    output logic                  load
);

    localparam int CW = 16;
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] c_div_last   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_setup_last = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] c_hold_last  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] c_gap_last   = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] c_bit_last   = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [BW-1:0]         r_bit, w_bit;
    // MSB goes straight to sdo on accept, so only the remaining bits are kept
    logic [FRAME_BITS-2:0] r_tx_rest, w_tx_rest;
    logic [FRAME_BITS-1:0] r_rx_shift, w_rx_shift;
    logic [FRAME_BITS-1:0] r_rx_frame, w_rx_frame;
    logic                  r_rx_valid, w_rx_valid;
    logic                  r_sck, w_sck;
    logic                  r_sdo, w_sdo;
    logic                  r_load, w_load;
    logic                  r_busy, w_busy;
    logic [CW-1:0]         w_cnt_inc;

    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx_rest  <= '0;
            r_rx_shift <= '0;
            r_rx_frame <= '0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_sdo      <= 1'b0;
            r_load     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_tx_rest  <= w_tx_rest;
            r_rx_shift <= w_rx_shift;
            r_rx_frame <= w_rx_frame;
            r_rx_valid <= w_rx_valid;
            r_sck      <= w_sck;
            r_sdo      <= w_sdo;
            r_load     <= w_load;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit      = r_bit;
        w_tx_rest  = r_tx_rest;
        w_rx_shift = r_rx_shift;
        w_rx_frame = r_rx_frame;
        w_rx_valid = 1'b0;
        w_sck      = r_sck;
        w_sdo      = r_sdo;
        w_load     = r_load;

        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_state   = ST_SETUP;
                    w_cnt     = '0;
                    w_bit     = '0;
                    w_tx_rest = tx_frame[FRAME_BITS-2:0];
                    w_sdo     = tx_frame[FRAME_BITS-1];
                    w_sck     = 1'b0;
                    w_load    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_setup_last) begin
                    w_state = ST_SHIFT;
                    w_cnt   = '0;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_div_last) begin
                    w_cnt = '0;
                    if (!r_sck) begin
                        w_sck      = 1'b1;
                        w_rx_shift = {r_rx_shift[FRAME_BITS-2:0], sdi};
                    end else begin
                        w_sck = 1'b0;
                        // last bit keeps sdo steady through the hold window
                        if (r_bit == c_bit_last) begin
                            w_state = ST_HOLD;
                        end else begin
                            w_bit     = r_bit + BW'(1);
                            w_sdo     = r_tx_rest[FRAME_BITS-2];
                            w_tx_rest = {r_tx_rest[FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_state    = ST_GAP;
                    w_cnt      = '0;
                    w_load     = 1'b0;
                    w_sdo      = 1'b0;
                    w_rx_frame = r_rx_shift;
                    w_rx_valid = 1'b1;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
                w_sck   = 1'b0;
                w_sdo   = 1'b0;
                w_load  = 1'b0;
            end
        endcase

        // abort overrides everything, including the rx_valid of a finishing hold
        if (abort && (r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD)) begin
            w_state    = ST_GAP;
            w_cnt      = '0;
            w_sck      = 1'b0;
            w_sdo      = 1'b0;
            w_load     = 1'b0;
            w_rx_valid = 1'b0;
            w_rx_frame = r_rx_frame;
        end

        w_busy = (w_state != ST_IDLE);
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign rx_frame = r_rx_frame;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign sck      = r_sck;
    assign sdo      = r_sdo;
    assign load     = r_load;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_master
// Function : Self-checking bench for spi_frame_master (default and fast timing)
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_master;

    localparam int FB    = 128;
    localparam int A_DIV = 4, A_SU = 2, A_HO = 2, A_GAP = 4;
    localparam int B_DIV = 1, B_SU = 1, B_HO = 1, B_GAP = 4;
    localparam int A_L   = A_SU + 2 * A_DIV * FB + A_HO;
    localparam int B_L   = B_SU + 2 * B_DIV * FB + B_HO;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [FB-1:0] a_tx_frame = '0, a_rx_frame;
    logic a_tx_valid = 1'b0, a_tx_ready, a_abort = 1'b0, a_rx_valid, a_busy;
    logic a_sck, a_sdo, a_load, a_sdi = 1'b0;
    logic [FB-1:0] b_tx_frame = '0, b_rx_frame;
    logic b_tx_valid = 1'b0, b_tx_ready, b_abort = 1'b0, b_rx_valid, b_busy;
    logic b_sck, b_sdo, b_load, b_sdi = 1'b0;

    spi_frame_master #(.FRAME_BITS(FB), .CLK_DIV(A_DIV), .CS_SETUP(A_SU),
                       .CS_HOLD(A_HO), .GAP_CYCLES(A_GAP)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .tx_frame(a_tx_frame), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .abort(a_abort), .rx_frame(a_rx_frame),
        .rx_valid(a_rx_valid), .busy(a_busy), .sck(a_sck), .sdo(a_sdo),
        .sdi(a_sdi), .load(a_load));

    spi_frame_master #(.FRAME_BITS(FB), .CLK_DIV(B_DIV), .CS_SETUP(B_SU),
                       .CS_HOLD(B_HO), .GAP_CYCLES(B_GAP)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .tx_frame(b_tx_frame), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .abort(b_abort), .rx_frame(b_rx_frame),
        .rx_valid(b_rx_valid), .busy(b_busy), .sck(b_sck), .sdo(b_sdo),
        .sdi(b_sdi), .load(b_load));

    // Responder + link observer for instance A: echo mode returns each received
    // bit one sck later, pattern mode shifts out a_resp MSB first on sck falls.
    logic [FB-1:0] a_resp = '0, a_mosi = '0;
    bit   a_echo = 1'b1;
    logic a_prev_load = 1'b0, a_prev_sck = 1'b0, a_last = 1'b0;
    int a_low = 0, a_last_low = 0, a_len = 0, a_rises = 0, a_rise_t = 0, a_k = 0;
    int a_bad = 0, a_hi = 0, a_noload = 0, a_srises = 0, a_rv_cnt = 0, a_rv_t = 0;

    always @(negedge clk) begin
        a_prev_load <= a_load;
        a_prev_sck  <= a_sck;
        if (a_load) a_low <= 0; else a_low <= a_low + 1;
        if (a_load && !a_prev_load) begin
            a_rises <= a_rises + 1; a_rise_t <= cyc; a_len <= 1;
            a_last_low <= a_low; a_k <= 1;
            a_sdi <= a_echo ? 1'b0 : a_resp[FB-1];
        end else if (a_load) begin
            a_len <= a_len + 1;
        end
        if (a_load && (a_tx_ready || !a_busy)) a_bad <= a_bad + 1;
        if (a_sck) begin
            a_hi <= a_hi + 1;
            if (!a_load) a_noload <= a_noload + 1;
        end
        if (a_sck && !a_prev_sck) begin
            a_srises <= a_srises + 1;
            a_mosi <= {a_mosi[FB-2:0], a_sdo};
            a_last <= a_sdo;
        end
        if (!a_sck && a_prev_sck && a_load && a_k < FB) begin
            a_sdi <= a_echo ? a_last : a_resp[FB-1-a_k];
            a_k <= a_k + 1;
        end
        if (a_rx_valid) begin a_rv_cnt <= a_rv_cnt + 1; a_rv_t <= cyc; end
    end

    // Echo responder + observer for instance B
    logic [FB-1:0] b_mosi = '0;
    logic b_prev_load = 1'b0, b_prev_sck = 1'b0, b_last = 1'b0;
    int b_len = 0, b_rise_t = 0, b_hi = 0, b_srises = 0, b_rv_cnt = 0, b_rv_t = 0;

    always @(negedge clk) begin
        b_prev_load <= b_load;
        b_prev_sck  <= b_sck;
        if (b_load && !b_prev_load) begin
            b_rise_t <= cyc; b_len <= 1; b_sdi <= 1'b0;
        end else if (b_load) begin
            b_len <= b_len + 1;
        end
        if (b_sck) b_hi <= b_hi + 1;
        if (b_sck && !b_prev_sck) begin
            b_srises <= b_srises + 1;
            b_mosi <= {b_mosi[FB-2:0], b_sdo};
            b_last <= b_sdo;
        end
        if (!b_sck && b_prev_sck && b_load) b_sdi <= b_last;
        if (b_rx_valid) begin b_rv_cnt <= b_rv_cnt + 1; b_rv_t <= cyc; end
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event within bound, want event", nm);
    endtask

    // Reference model: what the master must capture from the responder
    function automatic logic [FB-1:0] model_rx(input logic [FB-1:0] tx, input logic [FB-1:0] resp,
                                               input bit echo);
        return echo ? (tx >> 1) : resp;
    endfunction

    task automatic wait_ready_a();
        int n = 0;
        while (!a_tx_ready && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic run_a(input logic [FB-1:0] tx, input logic [FB-1:0] resp, input bit echo,
                         input logic [FB-1:0] exp_rx, input string nm);
        int n, rv0, sr0, hi0, bad0, nl0;
        a_resp = resp;
        a_echo = echo;
        wait_ready_a();
        rv0 = a_rv_cnt; sr0 = a_srises; hi0 = a_hi; bad0 = a_bad; nl0 = a_noload;
        a_tx_frame = tx;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        a_tx_frame = ~tx;
        n = 0;
        while (a_rv_cnt == rv0 && n < A_L + 50) begin @(negedge clk); n++; end
        if (n >= A_L + 50) begin
            timeout_fail({nm, "_rx_valid"});
        end else begin
            chk({nm, "_mosi"}, a_mosi, tx);
            chk({nm, "_load_len"}, a_len, A_L);
            chk({nm, "_sck_rises"}, a_srises - sr0, FB);
            chk({nm, "_sck_high"}, a_hi - hi0, FB * A_DIV);
            chk({nm, "_ready_busy"}, a_bad - bad0, 0);
            chk({nm, "_rv_latency"}, a_rv_t - a_rise_t, A_L);
            chk({nm, "_rx"}, a_rx_frame, exp_rx);
            repeat (8) @(negedge clk);
            chk({nm, "_rv_pulses"}, a_rv_cnt - rv0, 1);
            chk({nm, "_rx_stable"}, a_rx_frame, exp_rx);
            chk({nm, "_sck_noload"}, a_noload - nl0, 0);
        end
    endtask

    task automatic run_b(input logic [FB-1:0] tx, input string nm);
        int n, rv0, sr0, hi0;
        n = 0;
        while (!b_tx_ready && n < 100) begin @(negedge clk); n++; end
        rv0 = b_rv_cnt; sr0 = b_srises; hi0 = b_hi;
        b_tx_frame = tx;
        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        n = 0;
        while (b_rv_cnt == rv0 && n < B_L + 50) begin @(negedge clk); n++; end
        if (n >= B_L + 50) begin
            timeout_fail({nm, "_rx_valid"});
        end else begin
            chk({nm, "_mosi"}, b_mosi, tx);
            chk({nm, "_load_len"}, b_len, B_L);
            chk({nm, "_sck_rises"}, b_srises - sr0, FB);
            chk({nm, "_sck_high"}, b_hi - hi0, FB * B_DIV);
            chk({nm, "_rv_latency"}, b_rv_t - b_rise_t, B_L);
            chk({nm, "_rx"}, b_rx_frame, model_rx(tx, '0, 1'b1));
            repeat (6) @(negedge clk);
            chk({nm, "_rv_pulses"}, b_rv_cnt - rv0, 1);
        end
    endtask

    typedef struct {
        logic [FB-1:0] tx;
        logic [FB-1:0] resp;
        bit            echo;
        logic [FB-1:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [FB-1:0] tx, resp, prev_rx;
        int n, rv0, r0, sr0, t_rv1;
        bit echo;

        vecs[0] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0, 1'b1, '0};
        vecs[1] = '{128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0,
                    128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1357_9BDF, 1'b0, '0};
        vecs[2] = '{128'h8000_0000_0000_0000_0000_0000_0000_0001, '0, 1'b1, '0};
        vecs[3] = '{128'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, '0};
        foreach (vecs[i]) vecs[i].exp_rx = model_rx(vecs[i].tx, vecs[i].resp, vecs[i].echo);

        repeat (3) @(negedge clk);
        chk("rst_tx_ready", a_tx_ready, 1);
        chk("rst_load", a_load, 0);
        chk("rst_sck", a_sck, 0);
        chk("rst_sdo", a_sdo, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_rx_frame", a_rx_frame, 0);
        chk("rst_b_load", b_load, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_a(vecs[i].tx, vecs[i].resp, vecs[i].echo, vecs[i].exp_rx,
                                          $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            tx   = {$urandom, $urandom, $urandom, $urandom};
            resp = {$urandom, $urandom, $urandom, $urandom};
            echo = 1'($urandom_range(0, 1));
            run_a(tx, resp, echo, model_rx(tx, resp, echo), $sformatf("rnd%0d", i));
        end

        // abort while idle has no effect
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ready", a_tx_ready, 1);
        chk("idle_abort_busy", a_busy, 0);

        // back-to-back frames with tx_valid held high
        a_echo = 1'b1;
        r0 = a_rises; rv0 = a_rv_cnt;
        a_tx_frame = {16{8'hA5}};
        a_tx_valid = 1'b1;
        n = 0;
        while (a_rises == r0 && n < 50) begin @(negedge clk); n++; end
        a_tx_frame = {16{8'h5A}};
        n = 0;
        while (a_rv_cnt == rv0 && n < A_L + 50) begin @(negedge clk); n++; end
        if (n >= A_L + 50) timeout_fail("b2b_rv1");
        chk("b2b_mosi1", a_mosi, {16{8'hA5}});
        chk("b2b_rx1", a_rx_frame, model_rx({16{8'hA5}}, '0, 1'b1));
        t_rv1 = a_rv_t;
        n = 0;
        while (a_rises < r0 + 2 && n < 50) begin @(negedge clk); n++; end
        a_tx_valid = 1'b0;
        if (n >= 50) timeout_fail("b2b_second_accept");
        chk("b2b_load_low", a_last_low, A_GAP + 1);
        chk("b2b_accept_gap", a_rise_t - t_rv1, A_GAP + 1);
        n = 0;
        while (a_rv_cnt < rv0 + 2 && n < A_L + 50) begin @(negedge clk); n++; end
        if (n >= A_L + 50) timeout_fail("b2b_rv2");
        chk("b2b_mosi2", a_mosi, {16{8'h5A}});
        chk("b2b_rx2", a_rx_frame, model_rx({16{8'h5A}}, '0, 1'b1));

        // reset in the middle of bit 40
        wait_ready_a();
        rv0 = a_rv_cnt; sr0 = a_srises;
        a_tx_frame = {8{16'hF00F}};
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        n = 0;
        while (a_srises < sr0 + 40 && n < A_L) begin @(negedge clk); n++; end
        chk("mid_rst_pre_load", a_load, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_load", a_load, 0);
        chk("mid_rst_sck", a_sck, 0);
        chk("mid_rst_sdo", a_sdo, 0);
        chk("mid_rst_busy", a_busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_rv", a_rv_cnt - rv0, 0);
        chk("mid_rst_rx_frame", a_rx_frame, 0);
        tx = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        resp = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        run_a(tx, resp, 1'b0, model_rx(tx, resp, 1'b0), "post_rst");
        prev_rx = model_rx(tx, resp, 1'b0);

        // abort during bit 100
        wait_ready_a();
        a_resp = ~resp;
        a_echo = 1'b0;
        rv0 = a_rv_cnt; sr0 = a_srises;
        a_tx_frame = {4{32'h1357_2468}};
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        n = 0;
        while (a_srises < sr0 + 101 && n < A_L) begin @(negedge clk); n++; end
        chk("abort_pre_load", a_load, 1);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("abort_load", a_load, 0);
        chk("abort_sck", a_sck, 0);
        chk("abort_sdo", a_sdo, 0);
        n = 0;
        while (!a_tx_ready && n < 20) begin @(negedge clk); n++; end
        chk("abort_ready_delay", n, A_GAP);
        repeat (5) @(negedge clk);
        chk("abort_no_rv", a_rv_cnt - rv0, 0);
        chk("abort_rx_keep", a_rx_frame, prev_rx);

        // fast timing instance
        run_b({FB{1'b1}}, "fast_ones");
        run_b({FB{1'b0}}, "fast_zeros");

        // abort on the same edge that would end the hold window
        rv0 = b_rv_cnt;
        b_tx_frame = {FB{1'b1}};
        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        repeat (B_L - 1) @(negedge clk);
        chk("hold_abort_pre_load", b_load, 1);
        chk("hold_abort_pre_sck", b_sck, 0);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        chk("hold_abort_load", b_load, 0);
        chk("hold_abort_rv_now", b_rx_valid, 0);
        repeat (6) @(negedge clk);
        chk("hold_abort_no_rv", b_rv_cnt - rv0, 0);
        chk("hold_abort_rx_keep", b_rx_frame, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, want end of test");
        $fatal(1);
    end

endmodule
`default_nettype wire
